reset_sequencer: RTL and testbench

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_seq_pkg.sv | 22 ++
 rtl/reset_seq_timer.sv | 27 ++
 rtl/reset_sequencer.sv | 158 +++++++++++++++
 tb/tb_reset_sequencer.sv | 129 ++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the staged reset sequencer.
// RESET_SEQ_REVERSE_ASSERT_EN adds the DRAIN state for ordered teardown.
package reset_seq_pkg;

   localparam int TIMER_W = 8;
   localparam int STAGE_W = 3;

   localparam int DEF_NUM_STAGES    = 3;
   localparam int DEF_ASSERT_CYCLES = 4;
   localparam int DEF_STAGE_DELAY   = 2;

   typedef enum logic [1:0] {
      HOLD    = 2'd0,
      RELEASE = 2'd1,
      DONE    = 2'd2
`ifdef RESET_SEQ_REVERSE_ASSERT_EN
      ,
      DRAIN   = 2'd3
`endif
   } state_t;

endpackage

// File: rtl/reset_seq_timer.sv
// Loadable 8-bit down-counter that stops at zero.
// Reports zero so the sequencer can time holds and stage gaps.
module reset_seq_timer
   import reset_seq_pkg::*;
(
   input  logic               clk,
   input  logic               sync_reset_n,
   input  logic               load,
   input  logic [TIMER_W-1:0] value,
   output logic               zero
);

   logic [TIMER_W-1:0] count;

   always_ff @(posedge clk) begin
      if (!sync_reset_n) begin
         count <= '0;
      end else if (load) begin
         count <= value;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release with software-requested re-sequencing.
// RESET_SEQ_REVERSE_ASSERT_EN: tear stages down highest-first via DRAIN.
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int NUM_STAGES    = DEF_NUM_STAGES,
   parameter int ASSERT_CYCLES = DEF_ASSERT_CYCLES,
   parameter int STAGE_DELAY   = DEF_STAGE_DELAY
) (
   input  logic                  clk,
   input  logic                  sync_reset_n,
   input  logic                  sw_reset_req,
   output logic                  sw_reset_ack,
   output logic [NUM_STAGES-1:0] rst_out_n,
   output logic                  ready
);

   localparam logic [STAGE_W-1:0] LAST    = STAGE_W'(NUM_STAGES - 1);
   localparam logic [TIMER_W-1:0] HOLD_LD = TIMER_W'(ASSERT_CYCLES - 1);
   localparam logic [TIMER_W-1:0] STEP_LD = TIMER_W'(STAGE_DELAY - 1);

   state_t                 state_q, state_d;
   logic [STAGE_W-1:0]     stage_q, stage_d;
   logic [NUM_STAGES-1:0]  rst_q, rst_d;
   logic                   ready_q, ready_d;
   logic                   ack_q, ack_d;
   logic                   armed_q, armed_d;
   logic                   load;
   logic [TIMER_W-1:0]     value;
   logic                   zero;

   reset_seq_timer u_timer (
      .clk          (clk),
      .sync_reset_n (sync_reset_n),
      .load         (load),
      .value        (value),
      .zero         (zero)
   );

   always_ff @(posedge clk) begin
      if (!sync_reset_n) begin
         state_q <= HOLD;
         stage_q <= '0;
         rst_q   <= '0;
         ready_q <= 1'b0;
         ack_q   <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         state_q <= state_d;
         stage_q <= stage_d;
         rst_q   <= rst_d;
         ready_q <= ready_d;
         ack_q   <= ack_d;
         armed_q <= armed_d;
      end
   end

   always_comb begin
      state_d = state_q;
      stage_d = stage_q;
      rst_d   = rst_q;
      ready_d = ready_q;
      ack_d   = 1'b0;
      armed_d = armed_q;
      load    = 1'b0;
      value   = '0;
      case (state_q)
         HOLD: begin
            // first cycle out of reset starts the hold window
            if (!armed_q) begin
               armed_d = 1'b1;
               load    = 1'b1;
               value   = HOLD_LD;
            end else if (zero) begin
               rst_d[0] = 1'b1;
               state_d  = RELEASE;
               load     = 1'b1;
               if (NUM_STAGES == 1) begin
                  stage_d = '0;
                  value   = '0;
               end else begin
                  stage_d = STAGE_W'(1);
                  value   = STEP_LD;
               end
            end
         end
         RELEASE: begin
            if (zero) begin
               if (rst_q[NUM_STAGES-1]) begin
                  state_d = DONE;
                  ready_d = 1'b1;
               end else begin
                  for (int i = 0; i < NUM_STAGES; i++) begin
                     if (stage_q == STAGE_W'(i)) rst_d[i] = 1'b1;
                  end
                  load = 1'b1;
                  // last stage: one extra cycle before ready
                  if (stage_q == LAST) begin
                     value = '0;
                  end else begin
                     stage_d = stage_q + 1'b1;
                     value   = STEP_LD;
                  end
               end
            end
         end
         DONE: begin
            if (sw_reset_req) begin
               ack_d   = 1'b1;
               ready_d = 1'b0;
               load    = 1'b1;
`ifdef RESET_SEQ_REVERSE_ASSERT_EN
               rst_d[NUM_STAGES-1] = 1'b0;
               if (NUM_STAGES == 1) begin
                  state_d = HOLD;
                  stage_d = '0;
                  value   = HOLD_LD;
               end else begin
                  state_d = DRAIN;
                  stage_d = LAST;
                  value   = STEP_LD;
               end
`else
               rst_d   = '0;
               state_d = HOLD;
               stage_d = '0;
               value   = HOLD_LD;
`endif
            end
         end
`ifdef RESET_SEQ_REVERSE_ASSERT_EN
         DRAIN: begin
            if (zero) begin
               stage_d = stage_q - 1'b1;
               for (int i = 0; i < NUM_STAGES; i++) begin
                  if (stage_d == STAGE_W'(i)) rst_d[i] = 1'b0;
               end
               load = 1'b1;
               if (stage_d == '0) begin
                  state_d = HOLD;
                  value   = HOLD_LD;
               end else begin
                  value = STEP_LD;
               end
            end
         end
`endif
         default: begin
            state_d = HOLD;
         end
      endcase
   end

   assign sw_reset_ack = ack_q;
   assign rst_out_n    = rst_q;
   assign ready        = ready_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Randomized bench for reset_sequencer against an edge-count model.
// Honours RESET_SEQ_REVERSE_ASSERT_EN when it is defined globally.
module tb_reset_sequencer;

   localparam int N = 3;
   localparam int A = 4;
   localparam int D = 2;

   logic         clk = 1'b0;
   logic         sync_reset_n;
   logic         sw_reset_req;
   logic         sw_reset_ack;
   logic [N-1:0] rst_out_n;
   logic         ready;

   always #5 clk = ~clk;

   reset_sequencer #(
      .NUM_STAGES    (N),
      .ASSERT_CYCLES (A),
      .STAGE_DELAY   (D)
   ) dut (
      .clk          (clk),
      .sync_reset_n (sync_reset_n),
      .sw_reset_req (sw_reset_req),
      .sw_reset_ack (sw_reset_ack),
      .rst_out_n    (rst_out_n),
      .ready        (ready)
   );

   int n_chk  = 0;
   int n_pass = 0;
   int t      = 0;

   // model: sequence start edge e0, or drain start edge d0
   bit           waiting = 1'b1;
   bit           drain   = 1'b0;
   int           e0      = 0;
   int           d0      = 0;
   logic [N-1:0] m_rst   = '0;
   logic         m_ready = 1'b0;
   logic         m_ack   = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s edge=%0d got=%0h exp=%0h", tag, t, got, exp);
   endtask

   task automatic model(input logic rn, input logic req);
      m_ack = 1'b0;
      if (!rn) begin
         waiting = 1'b1;
         drain   = 1'b0;
         m_rst   = '0;
         m_ready = 1'b0;
         return;
      end
      if (waiting) begin
         waiting = 1'b0;
         e0      = t;
      end else if (m_ready && req) begin
         m_ack = 1'b1;
`ifdef RESET_SEQ_REVERSE_ASSERT_EN
         drain = 1'b1;
         d0    = t;
`else
         e0    = t;
`endif
      end
      if (drain && t == d0 + (N-1)*D) begin
         drain = 1'b0;
         e0    = t;
      end
      for (int i = 0; i < N; i++) begin
         if (drain) m_rst[i] = (t < d0 + (N-1-i)*D);
         else       m_rst[i] = (t >= e0 + A + i*D);
      end
      m_ready = !drain && (t >= e0 + A + (N-1)*D + 1);
   endtask

   task automatic cycle(input logic rn, input logic req);
      @(negedge clk);
      sync_reset_n = rn;
      sw_reset_req = req;
      @(posedge clk);
      t++;
      model(rn, req);
      #1;
      chk("rst_out_n", 32'(rst_out_n), 32'(m_rst));
      chk("ready", 32'(ready), 32'(m_ready));
      chk("sw_reset_ack", 32'(sw_reset_ack), 32'(m_ack));
   endtask

   initial begin
      bit hold = 1'b0;
      sync_reset_n = 1'b0;
      sw_reset_req = 1'b0;
      // power-on sequence
      repeat (3) cycle(1'b0, 1'b0);
      repeat (12) cycle(1'b1, 1'b0);
      // single request pulse in DONE
      cycle(1'b1, 1'b1);
      repeat (16) cycle(1'b1, 1'b0);
      // request raised mid-release and held: back-to-back sequences
      repeat (2) cycle(1'b0, 1'b0);
      repeat (5) cycle(1'b1, 1'b0);
      repeat (40) cycle(1'b1, 1'b1);
      repeat (16) cycle(1'b1, 1'b0);
      // request held through reset, then reset at E0+7
      repeat (2) cycle(1'b0, 1'b1);
      repeat (7) cycle(1'b1, 1'b0);
      cycle(1'b0, 1'b0);
      repeat (14) cycle(1'b1, 1'b0);
      // random mix
      for (int k = 0; k < 600; k++) begin
         logic rn;
         logic rq;
         rn = ($urandom_range(0, 49) != 0);
         if ($urandom_range(0, 15) == 0) hold = !hold;
         rq = hold | ($urandom_range(0, 7) == 0);
         cycle(rn, rq);
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
